// File: rtl/op_dispatcher.sv
// Command front-end for the four-lane processor array: FIFO-buffered commands are
// issued round-robin to idle lanes, watched by per-lane watchdogs, and returned tagged.
module op_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_A,
  input  logic [7:0]             cmd_B,
  input  logic [3:0]             cmd_op,
  input  logic [7:0]             cmd_addr,
  input  logic [3:0]             cmd_tag,
  output logic [3:0][7:0]        A,
  output logic [3:0][7:0]        B,
  output logic [3:0][3:0]        op,
  output logic [3:0][7:0]        address,
  output logic [3:0]             start,
  input  logic [3:0]             done,
  input  logic [3:0][15:0]       result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_result,
  output logic [3:0]             rsp_tag,
  output logic [1:0]             rsp_lane,
  output logic                   rsp_timeout,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] addr;
    logic [3:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} lane_st_t;

  cmd_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  lane_st_t        r_st  [4];
  logic [7:0]      r_wd  [4];
  logic [3:0]      r_tag [4];
  logic [15:0]     r_res [4];
  logic            r_to  [4];
  logic [1:0]      r_rr;

  logic            w_push;
  logic            w_empty;
  cmd_t            w_head;
  logic            w_disp;
  logic [1:0]      w_dlane;
  logic [1:0]      w_idx;
  logic            w_hsel;
  logic [1:0]      w_hlane;
  logic            w_rsp_load;
  logic            w_take;

  assign cmd_ready  = (r_count < CW'(DEPTH));
  assign fifo_count = r_count;
  assign w_push     = cmd_valid & cmd_ready;
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rptr];
  assign w_rsp_load = ~rsp_valid | rsp_ready;
  assign w_take     = w_rsp_load & w_hsel;

  // First idle lane at or after the round-robin pointer.
  always_comb begin
    w_disp  = 1'b0;
    w_dlane = '0;
    w_idx   = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_rr + 2'(k);
      if (!w_empty && !w_disp && r_st[w_idx] == S_IDLE) begin
        w_disp  = 1'b1;
        w_dlane = w_idx;
      end
    end
  end

  // Lowest-index lane holding a finished result.
  always_comb begin
    w_hsel  = 1'b0;
    w_hlane = '0;
    for (int l = 3; l >= 0; l--) begin
      if (r_st[l] == S_HOLD) begin
        w_hsel  = 1'b1;
        w_hlane = 2'(l);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{a: cmd_A, b: cmd_B, op: cmd_op, addr: cmd_addr, tag: cmd_tag};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_disp) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_disp)      r_count <= r_count + 1'b1;
      else if (!w_push && w_disp) r_count <= r_count - 1'b1;
    end
  end

  // Lane controllers; operand outputs keep their values after the lane finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < 4; l++) begin
        r_st[l]  <= S_IDLE;
        r_wd[l]  <= '0;
        r_tag[l] <= '0;
        r_res[l] <= '0;
        r_to[l]  <= 1'b0;
      end
      start   <= '0;
      A       <= '0;
      B       <= '0;
      op      <= '0;
      address <= '0;
      r_rr    <= '0;
    end else begin
      start <= '0;
      for (int l = 0; l < 4; l++) begin
        case (r_st[l])
          S_IDLE: begin
            if (w_disp && w_dlane == 2'(l)) begin
              r_st[l]    <= S_ISSUE;
              start[l]   <= 1'b1;
              A[l]       <= w_head.a;
              B[l]       <= w_head.b;
              op[l]      <= w_head.op;
              address[l] <= w_head.addr;
              r_tag[l]   <= w_head.tag;
            end
          end
          S_ISSUE: begin
            r_st[l] <= S_WAIT;
            r_wd[l] <= '0;
          end
          S_WAIT: begin
            r_wd[l] <= r_wd[l] + 1'b1;
            if (done[l]) begin
              r_st[l]  <= S_HOLD;
              r_res[l] <= result[l];
              r_to[l]  <= 1'b0;
            end else if (r_wd[l] == 8'(TIMEOUT - 1)) begin
              r_st[l]  <= S_HOLD;
              r_res[l] <= '0;
              r_to[l]  <= 1'b1;
            end
          end
          S_HOLD: begin
            if (w_take && w_hlane == 2'(l)) r_st[l] <= S_IDLE;
          end
          default: r_st[l] <= S_IDLE;
        endcase
      end
      if (w_disp) r_rr <= w_dlane + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_tag     <= '0;
      rsp_lane    <= '0;
      rsp_timeout <= 1'b0;
    end else if (w_rsp_load) begin
      if (w_hsel) begin
        rsp_valid   <= 1'b1;
        rsp_result  <= r_res[w_hlane];
        rsp_tag     <= r_tag[w_hlane];
        rsp_lane    <= w_hlane;
        rsp_timeout <= r_to[w_hlane];
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_op_dispatcher.sv
// Bench for op_dispatcher: directed scenarios plus random traffic against a
// queue/timestamp reference model, with simulated processor lanes.
module tb_op_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] addr;
    logic [3:0] tag;
  } cmd_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_A, cmd_B, cmd_addr;
  logic [3:0]       cmd_op, cmd_tag;
  logic [3:0][7:0]  A, B, address;
  logic [3:0][3:0]  op;
  logic [3:0]       start;
  logic [3:0]       done;
  logic [3:0][15:0] result;
  logic             rsp_valid, rsp_ready, rsp_timeout;
  logic [15:0]      rsp_result;
  logic [3:0]       rsp_tag;
  logic [1:0]       rsp_lane;
  logic [$clog2(DEPTH):0] fifo_count;

  op_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_tag(cmd_tag),
    .A(A), .B(B), .op(op), .address(address), .start(start),
    .done(done), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_lane(rsp_lane), .rsp_timeout(rsp_timeout),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending commands in a queue, each lane a phase plus the
  // cycle stamp at which it began waiting.
  cmd_t        q[$];
  int          ph[4];        // 0 free, 1 issuing, 2 waiting, 3 finished
  int          t_wait[4];
  cmd_t        lc[4];
  logic [15:0] lres[4];
  logic        lto[4];
  int          rr;
  int          cyc;
  logic        mrv, mto;
  logic [15:0] mres;
  logic [3:0]  mtag;
  logic [1:0]  mlane;
  logic [3:0]  mstart;

  // Simulated lanes: countdown to done per lane; 0 = nothing pending.
  int cnt[4];
  int lat_plan;
  bit rnd_lat;
  bit seen_rsp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int l = 0; l < 4; l++) begin
      ph[l] = 0; t_wait[l] = 0; lc[l] = '0; lres[l] = '0; lto[l] = 1'b0; cnt[l] = 0;
    end
    rr = 0; mrv = 0; mto = 0; mres = '0; mtag = '0; mlane = '0; mstart = '0;
    done = '0;
  endtask

  task automatic model_step();
    int   nph[4];
    bit   push;
    bit   found;
    int   h;
    int   ln;
    cmd_t nc;
    cyc++;
    push = cmd_valid && (q.size() < DEPTH);
    nc.a = cmd_A; nc.b = cmd_B; nc.op = cmd_op; nc.addr = cmd_addr; nc.tag = cmd_tag;
    for (int l = 0; l < 4; l++) nph[l] = ph[l];
    for (int l = 0; l < 4; l++) begin
      if (ph[l] == 1) begin
        nph[l] = 2; t_wait[l] = cyc;
      end else if (ph[l] == 2) begin
        if (done[l]) begin
          nph[l] = 3; lres[l] = result[l]; lto[l] = 1'b0;
        end else if (cyc - t_wait[l] == TIMEOUT) begin
          nph[l] = 3; lres[l] = 16'h0000; lto[l] = 1'b1;
        end
      end
    end
    if (!mrv || rsp_ready) begin
      h = -1;
      for (int l = 3; l >= 0; l--) if (ph[l] == 3) h = l;
      if (h >= 0) begin
        mrv = 1'b1; mres = lres[h]; mtag = lc[h].tag; mlane = 2'(h); mto = lto[h]; nph[h] = 0;
      end else begin
        mrv = 1'b0;
      end
    end
    mstart = '0;
    found = 0;
    if (q.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        ln = (rr + k) % 4;
        if (!found && ph[ln] == 0) begin
          found = 1; nph[ln] = 1; lc[ln] = q.pop_front(); mstart[ln] = 1'b1; rr = (ln + 1) % 4;
        end
      end
    end
    if (push) q.push_back(nc);
    for (int l = 0; l < 4; l++) ph[l] = nph[l];
  endtask

  task automatic compare_all();
    chk("cmd_ready", 64'(cmd_ready), 64'(q.size() < DEPTH));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    chk("start", 64'(start), 64'(mstart));
    chk("rsp_valid", 64'(rsp_valid), 64'(mrv));
    chk("rsp_result", 64'(rsp_result), 64'(mres));
    chk("rsp_tag", 64'(rsp_tag), 64'(mtag));
    chk("rsp_lane", 64'(rsp_lane), 64'(mlane));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(mto));
    for (int l = 0; l < 4; l++)
      chk($sformatf("lane%0d_ops", l), 64'({A[l], B[l], op[l], address[l]}),
          64'({lc[l].a, lc[l].b, lc[l].op, lc[l].addr}));
    if (rsp_valid) seen_rsp = 1;
  endtask

  task automatic respond();
    for (int l = 0; l < 4; l++) begin
      done[l] = 1'b0;
      result[l] = 16'($urandom);
      if (mstart[l]) begin
        if (rnd_lat) cnt[l] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
        else         cnt[l] = (lat_plan < 0) ? 0 : lat_plan;
      end else if (cnt[l] > 0) begin
        cnt[l]--;
        if (cnt[l] == 0) begin
          done[l] = 1'b1;
          result[l] = 16'(lc[l].a) + 16'(lc[l].b);
        end
      end else if (rnd_lat && $urandom_range(0, 15) == 0) begin
        done[l] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    @(negedge clk);
    compare_all();
    respond();
  endtask

  task automatic set_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o,
                         input logic [7:0] ad, input logic [3:0] t);
    cmd_A = a; cmd_B = b; cmd_op = o; cmd_addr = ad; cmd_tag = t;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    rnd_lat = 0;
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
  endtask

  task automatic run_timeout(input int lat, input logic exp_to, input logic [15:0] exp_res);
    do_reset();
    rsp_ready = 1'b1;
    lat_plan = lat;
    cmd_valid = 1'b1;
    set_cmd(8'd9, 8'd4, 4'd2, 8'h40, 4'd5);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("to_start", 64'(start), 64'b0001);
    repeat (TIMEOUT + 1) tick();
    chk("to_rsp_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("to_rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
    chk("to_rsp_result", 64'(rsp_result), 64'(exp_res));
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit started;
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    done = '0; result = '0; cyc = 0; lat_plan = 0; rnd_lat = 0;
    set_cmd(8'd0, 8'd0, 4'd0, 8'd0, 4'd0);
    model_reset();

    // Single operation
    do_reset();
    lat_plan = 3;
    cmd_valid = 1'b1;
    set_cmd(8'd3, 8'd5, 4'd1, 8'h20, 4'd7);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("single_start", 64'(start), 64'b0001);
    repeat (4) tick();
    chk("single_rsp_early", 64'(rsp_valid), 64'd0);
    tick();
    chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("single_rsp_result", 64'(rsp_result), 64'h0008);
    chk("single_rsp_tag", 64'(rsp_tag), 64'd7);
    chk("single_rsp_lane", 64'(rsp_lane), 64'd0);
    chk("single_rsp_timeout", 64'(rsp_timeout), 64'd0);
    repeat (3) tick();

    // Round-robin issue and a fifth command waiting for a free lane
    do_reset();
    lat_plan = -1;
    cmd_valid = 1'b1;
    set_cmd(8'd1, 8'd2, 4'd0, 8'h00, 4'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      set_cmd(8'(i + 1), 8'(i * 3), 4'(i), 8'(i * 16), 4'(i));
      tick();
      chk($sformatf("rr_start%0d", i - 1), 64'(start), 64'(4'b0001 << (i - 1)));
    end
    chk("rr_queued", 64'(fifo_count), 64'd1);
    cmd_valid = 1'b0;
    seen_rsp = 0;
    started = 0;
    for (int i = 0; i < 40 && !started; i++) begin
      tick();
      if (start != 4'b0000) started = 1;
      else chk("rr_still_queued", 64'(fifo_count), 64'd1);
    end
    chk("rr_fifth_started", 64'(started), 64'd1);
    chk("rr_fifth_lane", 64'(start), 64'b0001);
    chk("rr_rsp_before_fifth", 64'(seen_rsp), 64'd1);
    repeat (30) tick();

    // Full FIFO with hung lanes and a stalled response port
    do_reset();
    lat_plan = -1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4 + DEPTH + 1; i++) begin
      set_cmd(8'(i), 8'(i + 100), 4'(i), 8'(i), 4'(i));
      tick();
      if (i == 2 + DEPTH) chk("full_ready_before", 64'(cmd_ready), 64'd1);
      if (i == 3 + DEPTH) begin
        chk("full_ready_drop", 64'(cmd_ready), 64'd0);
        chk("full_count", 64'(fifo_count), 64'(DEPTH));
      end
      if (i == 4 + DEPTH) chk("full_extra_ignored", 64'(fifo_count), 64'(DEPTH));
    end
    cmd_valid = 1'b0;
    repeat (20) tick();
    rsp_ready = 1'b1;
    repeat (60) tick();

    // Watchdog expiry, done on the expiry edge, done one edge late
    run_timeout(-1, 1'b1, 16'h0000);
    run_timeout(TIMEOUT, 1'b0, 16'd13);
    run_timeout(TIMEOUT + 1, 1'b1, 16'h0000);
    repeat (5) tick();

    // Reset while two lanes wait and a third is issuing
    do_reset();
    lat_plan = -1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(8'(i + 7), 8'(i), 4'(i), 8'(i), 4'(i + 8));
      tick();
    end
    cmd_valid = 1'b0;
    chk("midrst_start_before", 64'(start), 64'b0100);
    reset = 1'b0;
    #1;
    chk("midrst_start_low", 64'(start), 64'd0);
    chk("midrst_fifo_count", 64'(fifo_count), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    seen_rsp = 0;
    repeat (3 * TIMEOUT) tick();
    chk("midrst_no_response", 64'(seen_rsp), 64'd0);

    // Random traffic
    do_reset();
    rnd_lat = 1;
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      set_cmd(8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    rnd_lat = 0;
    lat_plan = 1;
    repeat (80) tick();
    chk("drain_fifo_empty", 64'(fifo_count), 64'd0);
    chk("drain_rsp_idle", 64'(rsp_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
